// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: memory-side responder for the write-back data cache.
// Serialises block write-backs and fills into word accesses on req/ack.
module cache_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic [31:0]                      req_addr,
  output logic                             req_ready,
  input  logic                             wb_valid,
  input  logic [31:0]                      wb_addr,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] wb_data,
  output logic                             wb_ready,
  output logic                             wb_overflow,
  output logic [DATA_WIDTH*BLOCK_SIZE-1:0] fetch_data,
  output logic                             fetch_enable,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [31:0]                      mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int BW = DATA_WIDTH * BLOCK_SIZE;
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int BLK_BYTES = BW / 8;
  localparam logic [31:0] BMASK = ~(32'(BLK_BYTES) - 32'd1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FETCH,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gap_q, gap_d;
  logic            wb_vld_q, wb_vld_d;
  logic [31:0]     wb_base_q, wb_base_d;
  logic [BW-1:0]   wb_data_q, wb_data_d;
  logic            pend_q, pend_d;
  logic [31:0]     req_base_q, req_base_d;
  logic [BW-1:0]   fdata_q, fdata_d;
  logic            ovf_q, ovf_d;

  function automatic logic [31:0] word_addr(
    input logic [31:0]   base,
    input logic [CW-1:0] idx
  );
    return base + 32'(idx) * 32'(WORD_BYTES);
  endfunction

  assign req_ready   = (state_q == IDLE) && !pend_q;
  assign wb_ready    = !wb_vld_q;
  assign wb_overflow = ovf_q;
  assign fetch_data  = fdata_q;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gap_q      <= 1'b0;
      wb_vld_q   <= 1'b0;
      wb_base_q  <= '0;
      wb_data_q  <= '0;
      pend_q     <= 1'b0;
      req_base_q <= '0;
      fdata_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      wb_vld_q   <= wb_vld_d;
      wb_base_q  <= wb_base_d;
      wb_data_q  <= wb_data_d;
      pend_q     <= pend_d;
      req_base_q <= req_base_d;
      fdata_q    <= fdata_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state, buffer capture and memory-port outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = 1'b0;
    wb_vld_d     = wb_vld_q;
    wb_base_d    = wb_base_q;
    wb_data_d    = wb_data_q;
    pend_d       = pend_q;
    req_base_d   = req_base_q;
    fdata_d      = fdata_q;
    ovf_d        = ovf_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fetch_enable = 1'b0;

    if (wb_valid) begin
      if (!wb_vld_q) begin
        wb_vld_d  = 1'b1;
        wb_base_d = wb_addr & BMASK;
        wb_data_d = wb_data;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (req_valid && req_ready) begin
      pend_d     = 1'b1;
      req_base_d = req_addr & BMASK;
    end

    unique case (state_q)
      IDLE: begin
        if (wb_vld_q) begin
          state_d = WB;
          cnt_d   = '0;
        end else if (pend_q) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = word_addr(wb_base_q, cnt_q);
        mem_wdata = wb_data_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
        if (mem_ack) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d    = '0;
            wb_vld_d = 1'b0;
            state_d  = pend_q ? FETCH : IDLE;
            gap_d    = pend_q;
          end
        end
      end
      FETCH: begin
        // First FETCH cycle after a write-back keeps mem_req low
        if (!gap_q) begin
          mem_req  = 1'b1;
          mem_addr = word_addr(req_base_q, cnt_q);
          if (mem_ack) begin
            fdata_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = RESP;
            end
          end
        end
      end
      RESP: begin
        fetch_enable = 1'b1;
        pend_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: randomized bench for cache_mem_ctrl.
// Memory responder, transaction scoreboard and block-level fill model.
module tb_cache_mem_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         wb_valid;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         wb_ready;
  logic         wb_overflow;
  logic [127:0] fetch_data;
  logic         fetch_enable;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  cache_mem_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .wb_overflow  (wb_overflow),
    .fetch_data   (fetch_data),
    .fetch_enable (fetch_enable),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int fe_cyc = 0;
  int fe_cnt = 0;
  int rd_acks = 0;
  int ack_dly = 0;
  int waitc = 0;
  bit spur = 1'b1;
  bit fill_out = 1'b0;

  tx_t          txq[$];
  logic [127:0] fq[$];
  logic [31:0]  ram[logic [31:0]];

  logic        pv_req, pv_ack, pv_we, fe_prev, gap_exp;
  logic [31:0] pv_addr, pv_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] blk(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory responder plus per-cycle checks against the model
  always @(negedge clk) begin
    tx_t t;
    if (!rst_n) begin
      mem_ack = 1'b0;
      pv_req  = 1'b0;
      pv_ack  = 1'b0;
      fe_prev = 1'b0;
      gap_exp = 1'b0;
      waitc   = 0;
    end else begin
      if (gap_exp) chk("wb_fetch_gap", 128'(mem_req), 128'd0);
      gap_exp = 1'b0;
      if (pv_req && !pv_ack) begin
        chk("stall_req", 128'(mem_req), 128'd1);
        chk("stall_addr", 128'(mem_addr), 128'(pv_addr));
        chk("stall_we", 128'(mem_we), 128'(pv_we));
        chk("stall_wdata", 128'(mem_wdata), 128'(pv_wdata));
      end
      if (fetch_enable) begin
        if (fe_prev) fail("fetch_enable_width");
        if (fq.size() == 0) fail("fetch_enable_unexpected");
        else chk("fetch_data", fetch_data, fq.pop_front());
        fe_cyc = cyc;
        fe_cnt++;
      end
      fe_prev = fetch_enable;
      if (fill_out) chk("req_ready_busy", 128'(req_ready), 128'd0);
      else if (txq.size() == 0 && fq.size() == 0)
        chk("req_ready_idle", 128'(req_ready), 128'd1);
      if (fetch_enable) fill_out = 1'b0;
      pv_req   = mem_req;
      pv_we    = mem_we;
      pv_addr  = mem_addr;
      pv_wdata = mem_wdata;
      if (mem_req && waitc >= ack_dly) begin
        mem_ack = 1'b1;
        waitc = 0;
        if (txq.size() == 0) begin
          fail("mem_access_unexpected");
        end else begin
          t = txq.pop_front();
          chk("tx_we", 128'(mem_we), 128'(t.we));
          chk("tx_addr", 128'(mem_addr), 128'(t.addr));
          if (t.we) begin
            chk("tx_wdata", 128'(mem_wdata), 128'(t.data));
            if (t.addr[3:2] == 2'b11 && txq.size() > 0 && !txq[0].we)
              gap_exp = 1'b1;
          end
        end
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = mem_rd(mem_addr);
          rd_acks++;
        end
      end else begin
        mem_ack = spur && !mem_req && ($urandom_range(0, 2) == 0);
        mem_rdata = $urandom;
        if (mem_req) waitc++;
        else waitc = 0;
      end
      pv_ack = mem_ack;
    end
  end

  task automatic do_op(input bit dw, input bit df, input logic [31:0] wa,
                       input logic [127:0] wd, input logic [31:0] ra);
    logic [127:0] e;
    logic [31:0]  b;
    int t;
    e = '0;
    @(negedge clk);
    t = 0;
    while (df && !req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("req_ready_timeout");
    if (dw) begin
      wb_valid = 1'b1;
      wb_addr  = wa;
      wb_data  = wd;
      for (int i = 0; i < 4; i++)
        txq.push_back(tx_t'{we: 1'b1, addr: blk(wa) + 32'(i * 4), data: wd[i*32 +: 32]});
    end
    if (df) begin
      req_valid = 1'b1;
      req_addr  = ra;
      b = blk(ra);
      for (int i = 0; i < 4; i++) begin
        e[i*32 +: 32] = (dw && blk(wa) == b) ? wd[i*32 +: 32] : mem_rd(b + 32'(i * 4));
        txq.push_back(tx_t'{we: 1'b0, addr: b + 32'(i * 4), data: 32'h0});
      end
    end
    @(posedge clk);
    #1;
    wb_valid  = 1'b0;
    req_valid = 1'b0;
    if (df) begin
      acc_cyc  = cyc;
      fq.push_back(e);
      fill_out = 1'b1;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((txq.size() != 0 || fq.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      fail("completion_timeout");
      txq.delete();
      fq.delete();
      fill_out = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0;
    return 32'h0000_3000 + 32'($urandom_range(0, 7)) * 32'd16;
  endfunction

  initial begin
    logic [127:0] wd;
    logic [31:0]  wa, ra;
    int op, t, fe0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    wb_valid = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 128'(mem_req), 128'd0);
    chk("rst_mem_we", 128'(mem_we), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_mem_wdata", 128'(mem_wdata), 128'd0);
    chk("rst_fetch_enable", 128'(fetch_enable), 128'd0);
    chk("rst_fetch_data", fetch_data, 128'd0);
    chk("rst_wb_overflow", 128'(wb_overflow), 128'd0);
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_wb_ready", 128'(wb_ready), 128'd1);
    rst_n = 1'b1;

    ram[32'h1230] = 32'hA0;
    ram[32'h1234] = 32'hA1;
    ram[32'h1238] = 32'hA2;
    ram[32'h123C] = 32'hA3;
    do_op(1'b0, 1'b1, 32'h0, 128'h0, 32'h0000_1234);
    wait_done();
    chk("clean_fill_data", fetch_data, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("clean_fill_latency", 128'(fe_cyc - acc_cyc + 1), 128'd6);

    do_op(1'b1, 1'b1, 32'h0000_0800, 128'h00000044_00000033_00000022_00000011, 32'h0000_1000);
    wait_done();
    chk("dirty_fill_latency", 128'(fe_cyc - acc_cyc + 1), 128'd11);
    chk("dirty_wb_word3", 128'(mem_rd(32'h80C)), 128'h44);

    wd = {$urandom, $urandom, $urandom, $urandom};
    do_op(1'b1, 1'b1, 32'h0000_2000, wd, 32'h0000_2008);
    wait_done();
    chk("same_block_fill", fetch_data, wd);

    ack_dly = 3;
    do_op(1'b0, 1'b1, 32'h0, 128'h0, 32'h0000_5550);
    wait_done();
    chk("slow_fill_latency", 128'(fe_cyc - acc_cyc + 1), 128'd18);
    do_op(1'b1, 1'b1, 32'h0000_6000, {$urandom, $urandom, $urandom, $urandom}, 32'h0000_6100);
    wait_done();

    ack_dly = 60;
    wd = 128'h0D0C0B0A_04030201_DEADBEEF_CAFEF00D;
    do_op(1'b1, 1'b0, 32'h0000_7000, wd, 32'h0);
    repeat (3) @(negedge clk);
    chk("ovf_before", 128'(wb_overflow), 128'd0);
    chk("wb_ready_full", 128'(wb_ready), 128'd0);
    wb_valid = 1'b1;
    wb_addr  = 32'h0000_7100;
    wb_data  = ~wd;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", 128'(wb_overflow), 128'd1);
    ack_dly = 0;
    wait_done();
    chk("ovf_held", 128'(wb_overflow), 128'd1);
    chk("ovf_first_block", {mem_rd(32'h700C), mem_rd(32'h7008), mem_rd(32'h7004), mem_rd(32'h7000)}, wd);

    rd_acks = 0;
    do_op(1'b0, 1'b1, 32'h0, 128'h0, 32'h0000_4440);
    t = 0;
    while (rd_acks < 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) fail("read_ack_timeout");
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    txq.delete();
    fq.delete();
    fill_out = 1'b0;
    fe0 = fe_cnt;
    @(negedge clk);
    chk("rst_mid_mem_req", 128'(mem_req), 128'd0);
    chk("rst_mid_req_ready", 128'(req_ready), 128'd1);
    chk("rst_mid_wb_ready", 128'(wb_ready), 128'd1);
    chk("rst_mid_ovf", 128'(wb_overflow), 128'd0);
    repeat (8) @(negedge clk);
    chk("rst_mid_no_fe", 128'(fe_cnt), 128'(fe0));
    do_op(1'b0, 1'b1, 32'h0, 128'h0, 32'h0000_4440);
    wait_done();
    chk("post_rst_fill_count", 128'(fe_cnt), 128'(fe0 + 1));

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      ack_dly = $urandom_range(0, 2);
      wa = pick() | 32'($urandom_range(0, 15));
      wd = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ra = blk(wa) | 32'($urandom_range(0, 15));
      else ra = pick() | 32'($urandom_range(0, 15));
      do_op(op != 1, op != 0, wa, wd, ra);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
- Memory-side responder for the 2-way write-back data cache.
- Accepts dirty-block write-backs (128-bit block plus block address) and block-fill requests from the cache.
- Serialises each block into four 32-bit word transfers on a req/ack main-memory port.
- Returns a filled block to the cache as a 128-bit fetch_data with a one-cycle fetch_enable pulse.

Parameters:
DATA_WIDTH, 32, word width
BLOCK_SIZE, 4, words per block (block = BLOCK_SIZE*DATA_WIDTH bits; word counter is 2 bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  cache miss: block fill requested
req_addr  in  32  miss address; block base = {req_addr[31:4],4'b0}
req_ready  out  1  request accepted when req_valid&&req_ready
wb_valid  in  1  one-cycle write-back pulse from cache
wb_addr  in  32  write-back block base address (bits[3:0] ignored)
wb_data  in  128  write-back block, word i at [i*32 +: 32]
wb_ready  out  1  write-back buffer empty
wb_overflow  out  1  sticky: wb_valid seen while buffer full
fetch_data  out  128  filled block, word i at [i*32 +: 32]
fetch_enable  out  1  one-cycle pulse: fetch_data valid
mem_req  out  1  word access request, held until mem_ack
mem_we  out  1  1=write, 0=read; stable while mem_req
mem_addr  out  32  word address
mem_wdata  out  32  write word
mem_ack  in  1  access done this cycle; sampled only while mem_req=1
mem_rdata  in  32  read word, valid with mem_ack when mem_we=0

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following, aborting any transfer mid-block with no partial fetch_enable:
  - FSM to IDLE; word counter 0.
  - Write-back buffer invalid; no pending request.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fetch_enable=0, fetch_data=0, wb_overflow=0, req_ready=1, wb_ready=1.
- Write-back buffer (one entry):
  - Captures wb_addr/wb_data on any edge with wb_valid=1 and buffer empty, in any state.
  - wb_valid=1 with buffer full: beat dropped, wb_overflow set (sticky until reset).
- Request latch:
  - req_valid&&req_ready latches the block base and sets pending.
  - req_ready = (state==IDLE) && !pending.
- FSM states IDLE, WB, FETCH, RESP:
  - IDLE: if buffer valid -> WB (priority over fetch, also when both arrive in the same cycle). Else if pending -> FETCH. Counter cleared on entry to WB/FETCH.
  - WB: mem_req=1, mem_we=1, mem_addr=wb_base+4*cnt, mem_wdata=word cnt. On mem_ack: cnt++. On ack with cnt==3: clear buffer; go to FETCH if pending, else IDLE.
  - FETCH: mem_req=1, mem_we=0, mem_addr=req_base+4*cnt. On mem_ack: store mem_rdata into fetch_data word cnt, cnt++. On ack with cnt==3 -> RESP.
  - RESP: fetch_enable=1 for exactly this cycle; clear pending; next state IDLE.
- mem_req drops for at least one cycle between phases: IDLE->WB/FETCH costs one cycle; WB->FETCH inserts one idle cycle with mem_req=0.
- mem_req may stay high across consecutive words of one block; address/we/wdata update on the edge after each ack.
- Latency, single-cycle ack:
  - Fill only: req accept -> fetch_enable at +6 cycles (1 IDLE, 4 FETCH, 1 RESP).
  - Dirty fill: +11 cycles (1 IDLE, 4 WB, 1 gap, 4 FETCH, 1 RESP).
- fetch_data holds its last value until the next fill overwrites it word by word. It is not cleared after RESP.
- mem_ack while mem_req=0 is ignored. Acks arriving in the same cycle mem_req rises are legal.
- Address arithmetic is 32-bit. Block base is aligned, so +12 never carries out of bit 3 (base 0xFFFFFFF0 -> last word 0xFFFFFFFC).
- Write-back to the same block as the pending fill completes before its reads, so the fill returns the written-back data.

Test Plan:
- Clean fill: rst_n low 2 cycles; req_addr=0x0000_1234; memory returns 0xA0,0xA1,0xA2,0xA3 for 0x1230..0x123C with ack next cycle -> mem_addr sequence 0x1230,0x1234,0x1238,0x123C with mem_we=0; fetch_enable one cycle; fetch_data=0x000000A3_000000A2_000000A1_000000A0.
- Dirty fill: wb_valid with wb_addr=0x0000_0800, wb_data=0x44_33_22_11 (words 0x11..0x44) in the same cycle as req_addr=0x1000 -> writes 0x800..0x80C with data 0x11,0x22,0x33,0x44 first, one mem_req=0 gap, then reads 0x1000..0x100C; fetch_enable 11 cycles after accept.
- Overflow: two wb_valid pulses while the first write-back waits on a stalled mem_ack -> second beat dropped, wb_overflow=1 and held; first block written intact.
- Slow memory: mem_ack delayed 3 cycles per word -> mem_req/mem_addr/mem_we stable through each stall; fetch_enable exactly one cycle; req_ready=0 throughout.
- Reset mid-fetch: rst_n=0 after 2 read acks -> next cycle mem_req=0, fetch_enable never pulses, req_ready=1, wb_ready=1; a new request then completes normally.
- Same-block write-back then fill at 0x2000, with memory modelled as RAM -> fetch_data equals the written-back wb_data.
